freq_meter: RTL

- Measures the frequency of an asynchronous square-wave input by counting its rising edges over a fixed gate window of system-clock cycles.
- It is the measuring counterpart of the clock divider: the divider generates a slow clock from i_clk_FPGA, and this block reads a slow signal back and reports its rate.
- With the default gate of FRECUENCY_IN cycles (1 s), the result is directly in Hz.
- Used for on-board self-check of generated clocks and for external signal inputs.

---
 rtl/freq_meter.sv | 102 ++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of i_signal over a gate
// window of GATE_CYCLES system clocks and reports the count, saturating on overflow.
module freq_meter #(
    parameter int FRECUENCY_IN = 50_000_000,
    parameter int GATE_CYCLES  = FRECUENCY_IN,
    parameter int COUNT_LENGTH = $clog2(FRECUENCY_IN),
    parameter int GATE_LENGTH  = $clog2(GATE_CYCLES)
) (
    input  logic                    i_clk_FPGA,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_signal,
    output logic [COUNT_LENGTH-1:0] o_frequency,
    output logic                    o_valid,
    output logic                    o_overflow,
    output logic                    o_busy
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [COUNT_LENGTH-1:0] EDGE_MAX  = '1;
    localparam logic [GATE_LENGTH-1:0]  GATE_LAST = GATE_LENGTH'(GATE_CYCLES - 1);

    state_t                  state;
    logic                    s1, s2, s3;
    logic                    edge_pulse;
    logic [GATE_LENGTH-1:0]  gate_cnt;
    logic [COUNT_LENGTH-1:0] edge_cnt;
    logic [COUNT_LENGTH-1:0] edge_next;
    logic                    ovf;
    logic                    ovf_next;
    logic                    at_max;
    logic                    last_cycle;

    assign edge_pulse = s2 & ~s3;
    assign at_max     = (edge_cnt == EDGE_MAX);
    assign last_cycle = (gate_cnt == GATE_LAST);

    // Count including this cycle's edge, so the last gate cycle is never lost.
    assign edge_next = (edge_pulse && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
    assign ovf_next  = ovf | (edge_pulse & at_max);

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_FPGA) begin
        if (i_reset) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
            o_frequency <= '0;
            o_valid     <= 1'b0;
            o_overflow  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            s1      <= i_signal;
            s2      <= s1;
            s3      <= s2;
            o_valid <= 1'b0;

            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                    if (i_enable) begin
                        state  <= MEASURE;
                        o_busy <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (last_cycle) begin
                        o_frequency <= edge_next;
                        o_overflow  <= ovf_next;
                        o_valid     <= 1'b1;
                        gate_cnt    <= '0;
                        edge_cnt    <= '0;
                        ovf         <= 1'b0;
                        if (!i_enable) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (!i_enable) begin
                        state    <= IDLE;
                        o_busy   <= 1'b0;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= edge_next;
                        ovf      <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
